// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit.
// Fetches one word at pc, holds it for decode, then advances pc by 4,
// takes a redirect, or stops on halt/fault. A fault flag is sticky until reset.
// Optional macro IFU_PERF_EN adds fetch and stall performance counters.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
`ifdef IFU_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        fetch_err
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_STOP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            err_q, err_d;
    logic            run_q;

    // Handshake and decision qualifiers shared by the FSM and datapath
    logic req_fire, rsp_ok, rsp_bad, adv, adv_halt, adv_redir, redir_bad;
    assign req_fire  = (state_q == S_REQ) && run_q && mem_req_ready;
    assign rsp_ok    = (state_q == S_WAIT) && mem_rsp_valid && !mem_rsp_err;
    assign rsp_bad   = (state_q == S_WAIT) && mem_rsp_valid && mem_rsp_err;
    assign adv       = (state_q == S_HOLD) && inst_ready;
    assign adv_halt  = adv && halt;
    assign adv_redir = adv && !halt && redirect_valid;
    assign redir_bad = adv_redir && (redirect_pc[1:0] != 2'b00);

    // State register; run_q keeps the request low until reset is seen released
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:  if (req_fire) state_d = S_WAIT;
            S_WAIT: begin
                if (rsp_ok)       state_d = S_HOLD;
                else if (rsp_bad) state_d = S_STOP;
            end
            S_HOLD: begin
                if (adv_halt || redir_bad) state_d = S_STOP;
                else if (adv)              state_d = S_REQ;
            end
            default: state_d = S_STOP;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        mem_req_valid = 1'b0;
        inst_valid    = 1'b0;
        case (state_q)
            S_REQ:   mem_req_valid = run_q;
            S_HOLD:  inst_valid    = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: capture on good response, pc update on advance
    always_comb begin
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        err_d     = err_q;
        if (rsp_ok) begin
            inst_d    = mem_rsp_data;
            inst_pc_d = pc_q;
        end
        if (rsp_bad || redir_bad) begin
            err_d = 1'b1;
        end
        if (adv && !adv_halt) begin
            if (adv_redir) begin
                if (!redir_bad) pc_d = redirect_pc;
            end else begin
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_PC;
            err_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
        end
    end

    assign mem_req_addr = pc_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign fetch_err    = err_q;

`ifdef IFU_PERF_EN
    logic [XLEN-1:0] fetch_cnt_q, stall_cnt_q;
    logic            stall_c;
    assign stall_c = (mem_req_valid && !mem_req_ready) || (state_q == S_WAIT);

    // Performance counters: decode handshakes and memory stall cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (adv)     fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            if (stall_c) stall_cnt_q <= stall_cnt_q + XLEN'(1);
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    // No performance counters in this build
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with an expected-instruction queue.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_err;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    int unsigned exp_fetch;
    logic [31:0] stall_base;
`endif

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
`ifdef IFU_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        mem_rsp_err    = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h8000_0000);
        chk("rst_addr", mem_req_addr, 32'h8000_0000);
`ifdef IFU_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        exp_fetch = 0;
`endif
        rst_n = 1'b1;
        step();
    endtask

    // One fetch: request at exp_addr, response data (or fault), result checked from the queue
    task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data,
                             input logic err, input logic stale);
        int n;
        logic [63:0] e;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("req_valid", 32'(mem_req_valid), 32'd1);
        chk("req_addr", mem_req_addr, exp_addr);
        mem_req_ready = 1'b1;
        if (stale) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hDEAD_BEEF;
        end
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        chk("wait_no_req", 32'(mem_req_valid), 32'd0);
        chk("wait_no_inst", 32'(inst_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        mem_rsp_err   = err;
        if (!err) sb_q.push_back({data, exp_addr});
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        if (err) begin
            chk("fault_err", 32'(fetch_err), 32'd1);
            chk("fault_no_inst", 32'(inst_valid), 32'd0);
        end else begin
            chk("inst_valid", 32'(inst_valid), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("inst", inst, e[63:32]);
                chk("inst_pc", inst_pc, e[31:0]);
            end else begin
                total++;
                bad++;
                $error("FAIL sb_underflow observed=empty expected=entry");
            end
        end
    endtask

    task automatic consume(input logic h, input logic rv, input logic [31:0] rpc);
        inst_ready     = 1'b1;
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        step();
        clear_inputs();
`ifdef IFU_PERF_EN
        exp_fetch++;
        chk("perf_fetch", perf_fetch_cnt, 32'(exp_fetch));
`endif
    endtask

    task automatic expect_stopped(input string tag, input logic [31:0] exp_err);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_no_req"}, 32'(mem_req_valid), 32'd0);
            chk({tag, "_no_inst"}, 32'(inst_valid), 32'd0);
            step();
        end
        chk({tag, "_err"}, 32'(fetch_err), exp_err);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // Reset then first fetch with latency from reset release
        do_reset();
        fetch_one(32'h8000_0000, 32'h0000_0093, 1'b0, 1'b0);
        consume(1'b0, 1'b0, 32'h0);

        // Request held not ready for five cycles, address stable
`ifdef IFU_PERF_EN
        stall_base = perf_stall_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(mem_req_valid), 32'd1);
            chk("stall_addr", mem_req_addr, 32'h8000_0004);
            step();
        end
`ifdef IFU_PERF_EN
        chk("perf_stall5", perf_stall_cnt - stall_base, 32'd5);
`endif

        // Response in the acceptance cycle is ignored; sequential pc+4
        fetch_one(32'h8000_0004, 32'h0010_0113, 1'b0, 1'b1);

        // Hold with decode stalled; redirect/halt must be ignored meanwhile
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_inst", inst, 32'h0010_0113);
            chk("hold_pc", inst_pc, 32'h8000_0004);
        end
        clear_inputs();
        consume(1'b0, 1'b1, 32'h8000_0100);

        // Redirect target, then redirect to top of address space and wrap
        fetch_one(32'h8000_0100, 32'h4020_8233, 1'b0, 1'b0);
        consume(1'b0, 1'b1, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h0000_0063, 1'b0, 1'b0);
        consume(1'b0, 1'b0, 32'h0);
        fetch_one(32'h0000_0000, 32'h0000_006F, 1'b0, 1'b0);
        consume(1'b0, 1'b0, 32'h0);

        // Misaligned redirect faults and leaves pc unchanged
        fetch_one(32'h0000_0004, 32'h0000_0067, 1'b0, 1'b0);
        consume(1'b0, 1'b1, 32'h8000_0102);
        chk("misalign_pc", mem_req_addr, 32'h0000_0004);
        expect_stopped("misalign", 32'd1);

        // Halt wins over redirect and stops without a fault
        do_reset();
        fetch_one(32'h8000_0000, 32'h0010_0073, 1'b0, 1'b0);
        consume(1'b1, 1'b1, 32'h8000_0200);
        expect_stopped("halt", 32'd0);

        // Access fault on the response
        do_reset();
        fetch_one(32'h8000_0000, 32'h1234_5678, 1'b1, 1'b0);
        expect_stopped("rsp_fault", 32'd1);

        // Reset while waiting; response after release is ignored
        do_reset();
        chk("abort_req", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0_0BAD;
        step();
        mem_rsp_valid = 1'b0;
        chk("abort_req_valid", 32'(mem_req_valid), 32'd1);
        chk("abort_addr", mem_req_addr, 32'h8000_0000);
        chk("abort_inst", inst, 32'h0000_0013);
        chk("abort_inst_valid", 32'(inst_valid), 32'd0);
        step();
        chk("abort_still_req", 32'(mem_req_valid), 32'd1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
